// File: rtl/sdc_pkg.sv
// Shared constants and state encoding for the SD card controller sector-buffer sequencers.
// Imported by the block read/write sequencers and their helpers.
package sdc_pkg;

  localparam int SDC_ADDR_W    = 11;
  localparam int SDC_DATA_W    = 64;
  localparam int SDC_BLK_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } blk_rd_state_t;

endpackage

// File: rtl/sdc_sync_fifo.sv
// Synchronous FIFO with occupancy count and flush; one-cycle write-to-read latency.
// Pushes are dropped when full unless a pop frees a slot in the same cycle.
module sdc_sync_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop      = i_pop && (r_count != '0);
  assign w_push     = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdc_blk_rd_ctrl.sv
// Block-read sequencer: streams one buffer block as valid/ready words, first word 3 clk after start.
// SDC_BLK_RD_BYTESWAP_EN reverses byte order of each word at FIFO write.
module sdc_blk_rd_ctrl
  import sdc_pkg::*;
#(
  parameter int ADDR_W     = SDC_ADDR_W,
  parameter int DATA_W     = SDC_DATA_W,
  parameter int BLK_WORDS  = SDC_BLK_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  logic [ADDR_W-$clog2(BLK_WORDS)-1:0] blk_num,
  output logic                                busy,
  output logic                                done,
  output logic                                aborted,
  output logic [ADDR_W-1:0]                   bram_addr,
  input  logic [DATA_W-1:0]                   bram_dout,
  output logic [DATA_W-1:0]                   m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                m_last
);

  localparam int LOG_W = $clog2(BLK_WORDS);
  localparam int BLK_W = ADDR_W - LOG_W;
  localparam int IDX_W = LOG_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int USE_W = CNT_W + 1;

  blk_rd_state_t    r_state;
  blk_rd_state_t    w_next;
  logic [BLK_W-1:0] r_blk;
  logic [IDX_W-1:0] r_word_idx;
  logic             r_s1_vld;
  logic             r_s1_last;
  logic             r_s2_vld;
  logic             r_s2_last;
  logic             w_issue;
  logic             w_start_ok;
  logic             w_flush;
  logic             w_last_issue;
  logic             w_credit_ok;
  logic             w_hs_last;
  logic [USE_W-1:0] w_used;
  logic [CNT_W-1:0] w_fifo_cnt;
  logic             w_fifo_empty;
  logic [DATA_W:0]  w_head;
  logic [DATA_W-1:0] w_wr_dat;

  // Credit covers words already queued plus both read-pipeline stages.
  assign w_used       = {1'b0, w_fifo_cnt} + USE_W'(r_s1_vld) + USE_W'(r_s2_vld);
  assign w_credit_ok  = (w_used < USE_W'(FIFO_DEPTH));
  assign w_last_issue = (r_word_idx == IDX_W'(BLK_WORDS - 1));
  assign m_valid      = !w_fifo_empty;
  assign m_last       = m_valid && w_head[DATA_W];
  assign m_data       = w_head[DATA_W-1:0];
  assign w_hs_last    = m_valid && m_ready && m_last;
  assign busy         = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_issue    = 1'b0;
    w_start_ok = 1'b0;
    w_flush    = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    if (abort) begin
      w_next  = IDLE;
      w_flush = 1'b1;
      aborted = !reset && (r_state != IDLE);
    end else begin
      case (r_state)
        IDLE: if (start) begin
          w_next     = FETCH;
          w_start_ok = 1'b1;
        end
        FETCH: if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_last_issue) w_next = DRAIN;
        end
        DRAIN: if (w_hs_last) begin
          done   = !reset;
          w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk      <= '0;
      r_word_idx <= '0;
      bram_addr  <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_blk      <= blk_num;
        r_word_idx <= '0;
      end
      if (w_issue) begin
        bram_addr  <= {r_blk, r_word_idx[LOG_W-1:0]};
        r_word_idx <= r_word_idx + IDX_W'(1);
      end
      r_s1_vld  <= w_issue;
      r_s1_last <= w_last_issue;
      r_s2_vld  <= r_s1_vld && !w_flush;
      r_s2_last <= r_s1_last;
    end
  end

`ifdef SDC_BLK_RD_BYTESWAP_EN
  for (genvar b = 0; b < DATA_W / 8; b++) begin : g_swap
    assign w_wr_dat[8*b +: 8] = bram_dout[8*(DATA_W/8-1-b) +: 8];
  end
`else
  assign w_wr_dat = bram_dout;
`endif

  sdc_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (w_flush),
    .i_push     (r_s2_vld),
    .i_push_dat ({r_s2_last, w_wr_dat}),
    .i_pop      (m_ready),
    .o_head_dat (w_head),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_cnt)
  );

endmodule

// File: tb/tb_sdc_blk_rd_ctrl.sv
// Directed-plus-random bench for sdc_blk_rd_ctrl against a block-level expected-word model.
module tb_sdc_blk_rd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  blk_num;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [10:0] bram_addr;
  logic [63:0] bram_dout;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  logic [63:0] mem [2048];
  logic [63:0] first_seen;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) bram_dout <= mem[bram_addr];

  sdc_blk_rd_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .blk_num   (blk_num),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int a);
    logic [63:0] w;
    logic [63:0] s;
    w = mem[a];
    s = w;
`ifdef SDC_BLK_RD_BYTESWAP_EN
    for (int b = 0; b < 8; b++) s[8*b +: 8] = w[8*(7-b) +: 8];
`endif
    return s;
  endfunction

  // Called at a negedge with the DUT idle; the following posedge samples start.
  task automatic do_start(input int blk);
    start   = 1'b1;
    blk_num = 5'(blk);
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Runs one transfer from the negedge just after the start edge.
  task automatic stream(input int blk, input bit rnd, input bit stray,
                        input int abort_at, input int reset_at);
    int pops = 0;
    int cyc  = 0;
    int low  = 0;
    int off;
    bit hs;
    while (pops < 64) begin
      if (cyc > 3000) begin
        check("timeout_pops", 64'(pops), 64'd64);
        return;
      end
      if (!rnd)          m_ready = 1'b1;
      else if (low > 0) begin m_ready = 1'b0; low--; end
      else if ($urandom_range(0, 7) == 0) begin m_ready = 1'b0; low = $urandom_range(4, 24); end
      else               m_ready = 1'($urandom_range(0, 1));
      start   = stray && ($urandom_range(0, 3) == 0);
      blk_num = 5'($urandom);
      abort   = (pops == abort_at);
      reset   = (pops == reset_at);
      #1;
      if (abort || reset) begin
        check("aborted_pulse", 64'(aborted), 64'(abort));
        check("done_on_cancel", 64'(done), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("cancel_busy",    64'(busy),    64'd0);
        check("cancel_valid",   64'(m_valid), 64'd0);
        check("cancel_last",    64'(m_last),  64'd0);
        check("cancel_done",    64'(done),    64'd0);
        check("cancel_aborted", 64'(aborted), 64'd0);
        if (reset_at >= 0) check("reset_addr", 64'(bram_addr), 64'd0);
        return;
      end
      hs = m_valid && m_ready;
      check("done", 64'(done), 64'(hs && pops == 63));
      check("aborted_quiet", 64'(aborted), 64'd0);
      check("busy", 64'(busy), 64'd1);
      if (!rnd) check("valid_tput", 64'(m_valid), 64'(cyc >= 3));
      if (m_valid) begin
        check("data", m_data, exp_word(blk * 64 + pops));
        check("last", 64'(m_last), 64'(pops == 63));
      end
      if (cyc >= 1) begin
        off = int'(bram_addr[5:0]);
        check("addr_blk", 64'(bram_addr[10:6]), 64'(blk));
        check("lookahead", 64'(off + 1 - pops <= 4), 64'd1);
      end
      if (hs) begin
        if (pops == 0) first_seen = m_data;
        pops++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    #1;
    check("end_busy",  64'(busy),    64'd0);
    check("end_done",  64'(done),    64'd0);
    check("end_valid", 64'(m_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] key_exp;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    blk_num = '0;
    m_ready = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 64'h1000 + 64'(i);

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",    64'(busy),      64'd0);
    check("rst_done",    64'(done),      64'd0);
    check("rst_aborted", 64'(aborted),   64'd0);
    check("rst_valid",   64'(m_valid),   64'd0);
    check("rst_last",    64'(m_last),    64'd0);
    check("rst_addr",    64'(bram_addr), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Basic block 3, full throughput, then back-to-back random-backpressure blocks.
    do_start(3);
    stream(3, 1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom};
    do_start(17);
    stream(17, 1'b1, 1'b0, -1, -1);
    do_start(9);
    stream(9, 1'b1, 1'b1, -1, -1);

    // Abort mid-block, then a clean transfer on the top block.
    do_start(12);
    stream(12, 1'b1, 1'b0, 20, -1);
    do_start(31);
    stream(31, 1'b0, 1'b0, -1, -1);

    // start and abort together while idle.
    start   = 1'b1;
    abort   = 1'b1;
    blk_num = 5'd7;
    #1;
    check("idle_abort_pulse", 64'(aborted), 64'd0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("idle_abort_busy",  64'(busy),    64'd0);
    check("idle_abort_valid", 64'(m_valid), 64'd0);
    @(negedge clk);

    // Reset mid-block, then a following transfer.
    do_start(20);
    stream(20, 1'b1, 1'b0, -1, 40);
    do_start(21);
    stream(21, 1'b1, 1'b1, -1, -1);

    mem[5 * 64] = 64'h0011223344556677;
`ifdef SDC_BLK_RD_BYTESWAP_EN
    key_exp = 64'h7766554433221100;
`else
    key_exp = 64'h0011223344556677;
`endif
    do_start(5);
    stream(5, 1'b0, 1'b0, -1, -1);
    check("byte_order", first_seen, key_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
